// File: rtl/mealy_seq_det.sv
`default_nettype none
// ============================================================================
// Module      : mealy_seq_det
// Description : Parametrised Mealy serial pattern detector. One qualified bit
//               per clock is matched against PATTERN with a KMP automaton
//               whose transition table is built at elaboration time. The match
//               output is combinational (zero latency) and a saturating
//               counter tallies matches.
// Revision    : 1.0 - initial parametrised release (replaces fixed 2-bit FSM)
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   xe         in   1      serial data bit
//   xe_vld     in   1      qualifies xe; low = hold state/counter, ye = 0
//   clr        in   1      synchronous clear of state and counter
//   ye         out  1      Mealy match, same cycle as the final pattern bit
//   cur        out  SW     current state (matched-prefix length)
//   nxt        out  SW     combinational next state
//   match_cnt  out  CNT_W  saturating match count since reset/clr
//   cnt_sat    out  1      high while match_cnt is all ones
// ============================================================================
module mealy_seq_det #(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1011,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8,
    localparam int            SW      = (LEN < 2) ? 1 : $clog2(LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             xe,
    input  logic             xe_vld,
    input  logic             clr,
    output logic             ye,
    output logic [SW-1:0]    cur,
    output logic [SW-1:0]    nxt,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    // Number of encodable states; entries at or above LEN are unused.
    localparam int NS = 2 ** SW;

    // ------------------------------------------------------------------
    // Elaboration-time helpers
    // ------------------------------------------------------------------
    // Pattern bit i counted from the first bit received (i = 0 is MSB).
    function automatic logic pbit(input int i);
        logic [LEN-1:0] t;
        t = PATTERN >> (LEN - 1 - i);
        return t[0];
    endfunction

    // KMP transition: the string is the first k pattern bits followed by b.
    // Returns the longest j <= k+1 such that this string ends with the first
    // j pattern bits. A return of LEN (full match) is never looked up, since
    // the match path overrides the table.
    function automatic int kmp_next(input int k, input logic b);
        int   best;
        int   idx;
        logic ok;
        logic sb;
        best = 0;
        for (int j = 1; j <= LEN; j++) begin
            if (j <= k + 1) begin
                ok = 1'b1;
                for (int i = 0; i < LEN; i++) begin
                    if (i < j) begin
                        idx = k + 1 - j + i;
                        sb  = (idx == k) ? b : pbit(idx);
                        if (sb != pbit(i)) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    best = j;
                end
            end
        end
        return best;
    endfunction

    // Longest proper prefix of PATTERN that is also a suffix.
    function automatic int border();
        int   best;
        logic ok;
        best = 0;
        for (int j = 1; j < LEN; j++) begin
            ok = 1'b1;
            for (int i = 0; i < LEN; i++) begin
                if (i < j) begin
                    if (pbit(LEN - j + i) != pbit(i)) begin
                        ok = 1'b0;
                    end
                end
            end
            if (ok) begin
                best = j;
            end
        end
        return best;
    endfunction

    localparam logic [SW-1:0] c_last   = SW'(LEN - 1);
    localparam logic [SW-1:0] c_resume = OVERLAP ? SW'(border()) : '0;

    // ------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------
    if (LEN < 2 || LEN > 16) begin : g_len_check
        $error("mealy_seq_det: LEN=%0d outside legal range 2..16", LEN);
    end

    // ------------------------------------------------------------------
    // Constant transition table, one entry per encodable state
    // ------------------------------------------------------------------
    logic [SW-1:0] w_tab0  [NS];
    logic [SW-1:0] w_tab1  [NS];
    logic          w_valid [NS];

    for (genvar k = 0; k < NS; k++) begin : g_kmp
        if (k < LEN) begin : g_used
            localparam int c_n0 = kmp_next(k, 1'b0);
            localparam int c_n1 = kmp_next(k, 1'b1);
            assign w_tab0[k]  = SW'(c_n0);
            assign w_tab1[k]  = SW'(c_n1);
            assign w_valid[k] = 1'b1;
        end else begin : g_unused
            assign w_tab0[k]  = '0;
            assign w_tab1[k]  = '0;
            assign w_valid[k] = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    logic [SW-1:0]    cur_q;
    logic [SW-1:0]    cur_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             w_match;
    logic [SW-1:0]    w_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q <= '0;
            cnt_q <= '0;
        end else begin
            cur_q <= cur_d;
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_match = 1'b0;
        w_nxt   = cur_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;

        // rst gates ye directly so it drops before the register clears.
        w_match = xe_vld & ~rst & (cur_q == c_last) & (xe == PATTERN[0]);

        if (rst) begin
            w_nxt = '0;
        end else if (!w_valid[cur_q]) begin
            // Unreachable encodings recover to the idle state.
            w_nxt = '0;
        end else if (xe_vld) begin
            if (w_match) begin
                w_nxt = c_resume;
            end else begin
                w_nxt = xe ? w_tab1[cur_q] : w_tab0[cur_q];
            end
        end

        // clr wins over a simultaneous match: the pulse on ye still shows,
        // but the match is not counted.
        if (clr) begin
            cur_d = '0;
            cnt_d = '0;
        end else begin
            cur_d = w_nxt;
            if (w_match && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign ye        = w_match;
    assign cur       = cur_q;
    assign nxt       = w_nxt;
    assign match_cnt = cnt_q;
    assign cnt_sat   = (cnt_q == '1);

endmodule
`default_nettype wire

// File: tb/tb_mealy_seq_det.sv
`default_nettype none
// ============================================================================
// Module      : tb_mealy_seq_det
// Description : Directed, table-driven bench for mealy_seq_det. Three
//               instances share the inputs: A = defaults (1011, overlap),
//               B = 1011 non-overlapping, C = 1111 with a 2-bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mealy_seq_det;

    logic clk = 1'b0;
    logic rst;
    logic xe;
    logic xe_vld;
    logic clr;

    logic       ye_a, ye_b, ye_c;
    logic [1:0] cur_a, cur_b, cur_c;
    logic [1:0] nxt_a, nxt_b, nxt_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
    logic       sat_a, sat_b, sat_c;

    always #5 clk = ~clk;

    mealy_seq_det dut_a (
        .clk(clk), .rst(rst), .xe(xe), .xe_vld(xe_vld), .clr(clr),
        .ye(ye_a), .cur(cur_a), .nxt(nxt_a), .match_cnt(cnt_a), .cnt_sat(sat_a)
    );

    mealy_seq_det #(.OVERLAP(1'b0)) dut_b (
        .clk(clk), .rst(rst), .xe(xe), .xe_vld(xe_vld), .clr(clr),
        .ye(ye_b), .cur(cur_b), .nxt(nxt_b), .match_cnt(cnt_b), .cnt_sat(sat_b)
    );

    mealy_seq_det #(.PATTERN(4'b1111), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .xe(xe), .xe_vld(xe_vld), .clr(clr),
        .ye(ye_c), .cur(cur_c), .nxt(nxt_c), .match_cnt(cnt_c), .cnt_sat(sat_c)
    );

    typedef struct {
        int         d;     // 0 = A, 1 = B, 2 = C
        bit         rf;    // pulse reset before this vector
        logic       xe;
        logic       vld;
        logic       clr;
        logic       ye;    // expected ye while the bit is presented
        logic [1:0] cur;   // expected cur after the edge
        logic [7:0] cnt;   // expected match_cnt after the edge
        logic       sat;   // expected cnt_sat after the edge
    } vec_t;

    vec_t tbl[$];
    int   n_chk = 0;
    int   n_err = 0;

    function automatic vec_t mk(input int d, input bit rf, input logic x,
                                input logic v, input logic c, input logic y,
                                input logic [1:0] cu, input logic [7:0] cn,
                                input logic s);
        vec_t r;
        r.d = d; r.rf = rf; r.xe = x; r.vld = v; r.clr = c;
        r.ye = y; r.cur = cu; r.cnt = cn; r.sat = s;
        return r;
    endfunction

    task automatic add(input int d, input bit rf, input logic x, input logic v,
                       input logic c, input logic y, input logic [1:0] cu,
                       input logic [7:0] cn, input logic s);
        tbl.push_back(mk(d, rf, x, v, c, y, cu, cn, s));
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got %0h expected %0h", nm, idx, got, exp);
        end
    endtask

    task automatic sample(input int d, output logic y, output logic [1:0] c,
                          output logic [1:0] n, output logic [7:0] k,
                          output logic s);
        case (d)
            0:       begin y = ye_a; c = cur_a; n = nxt_a; k = cnt_a; s = sat_a; end
            1:       begin y = ye_b; c = cur_b; n = nxt_b; k = cnt_b; s = sat_b; end
            default: begin y = ye_c; c = cur_c; n = nxt_c; k = {6'b0, cnt_c}; s = sat_c; end
        endcase
    endtask

    // Called at posedge+1; leaves the bench at the following posedge+1.
    task automatic do_reset();
        rst = 1'b1; xe_vld = 1'b0; clr = 1'b0; xe = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Present one bit, check the Mealy outputs mid-cycle, then the registers.
    task automatic step(input vec_t v, input int idx);
        logic       y, s;
        logic [1:0] c, n;
        logic [7:0] k;
        xe = v.xe; xe_vld = v.vld; clr = v.clr;
        #3;
        sample(v.d, y, c, n, k, s);
        chk("ye", idx, {31'b0, y}, {31'b0, v.ye});
        if (!v.clr) chk("nxt", idx, {30'b0, n}, {30'b0, v.cur});
        @(posedge clk); #1;
        sample(v.d, y, c, n, k, s);
        chk("cur", idx, {30'b0, c}, {30'b0, v.cur});
        chk("match_cnt", idx, {24'b0, k}, {24'b0, v.cnt});
        chk("cnt_sat", idx, {31'b0, s}, {31'b0, v.sat});
    endtask

    initial begin
        // Reset state, with inputs that would otherwise advance the FSM.
        rst = 1'b1; xe = 1'b1; xe_vld = 1'b1; clr = 1'b0;
        #7;
        chk("rst_ye",  0, {31'b0, ye_a},  32'd0);
        chk("rst_cur", 0, {30'b0, cur_a}, 32'd0);
        chk("rst_nxt", 0, {30'b0, nxt_a}, 32'd0);
        chk("rst_cnt", 0, {24'b0, cnt_a}, 32'd0);
        chk("rst_sat", 0, {31'b0, sat_a}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // A: 1011011 with overlap -> matches on bits 4 and 7
        add(0,1, 1,1,0, 0,1,0,0); add(0,0, 0,1,0, 0,2,0,0);
        add(0,0, 1,1,0, 0,3,0,0); add(0,0, 1,1,0, 1,1,1,0);
        add(0,0, 0,1,0, 0,2,1,0); add(0,0, 1,1,0, 0,3,1,0);
        add(0,0, 1,1,0, 1,1,2,0);
        // B: same stream, non-overlapping -> only bit 4
        add(1,1, 1,1,0, 0,1,0,0); add(1,0, 0,1,0, 0,2,0,0);
        add(1,0, 1,1,0, 0,3,0,0); add(1,0, 1,1,0, 1,0,1,0);
        add(1,0, 0,1,0, 0,0,1,0); add(1,0, 1,1,0, 0,1,1,0);
        add(1,0, 1,1,0, 0,1,1,0);
        // A: 101, three idle cycles with xe toggling, then the final 1
        add(0,1, 1,1,0, 0,1,0,0); add(0,0, 0,1,0, 0,2,0,0);
        add(0,0, 1,1,0, 0,3,0,0); add(0,0, 1,0,0, 0,3,0,0);
        add(0,0, 0,0,0, 0,3,0,0); add(0,0, 1,0,0, 0,3,0,0);
        add(0,0, 1,1,0, 1,1,1,0);
        // C: eight 1s against 1111, 2-bit counter saturates at 3
        add(2,1, 1,1,0, 0,1,0,0); add(2,0, 1,1,0, 0,2,0,0);
        add(2,0, 1,1,0, 0,3,0,0); add(2,0, 1,1,0, 1,3,1,0);
        add(2,0, 1,1,0, 1,3,2,0); add(2,0, 1,1,0, 1,3,3,1);
        add(2,0, 1,1,0, 1,3,3,1); add(2,0, 1,1,0, 1,3,3,1);
        // A: one counted match, then clr coincides with the next matching bit
        add(0,1, 1,1,0, 0,1,0,0); add(0,0, 0,1,0, 0,2,0,0);
        add(0,0, 1,1,0, 0,3,0,0); add(0,0, 1,1,0, 1,1,1,0);
        add(0,0, 0,1,0, 0,2,1,0); add(0,0, 1,1,0, 0,3,1,0);
        add(0,0, 1,1,1, 1,0,0,0); add(0,0, 1,1,0, 0,1,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rf) do_reset();
            step(tbl[i], i);
        end
        clr = 1'b0;

        // Asynchronous reset mid-pattern: bring A to cur=3 with one match.
        do_reset();
        step(mk(0,0, 1,1,0, 0,1,0,0), 100);
        step(mk(0,0, 0,1,0, 0,2,0,0), 101);
        step(mk(0,0, 1,1,0, 0,3,0,0), 102);
        step(mk(0,0, 1,1,0, 1,1,1,0), 103);
        step(mk(0,0, 0,1,0, 0,2,1,0), 104);
        step(mk(0,0, 1,1,0, 0,3,1,0), 105);
        xe = 1'b1; xe_vld = 1'b1;
        #1;
        chk("pre_rst_ye", 106, {31'b0, ye_a}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_cur", 107, {30'b0, cur_a}, 32'd0);
        chk("async_cnt", 107, {24'b0, cnt_a}, 32'd0);
        chk("async_sat", 107, {31'b0, sat_a}, 32'd0);
        chk("async_ye",  107, {31'b0, ye_a},  32'd0);
        chk("async_nxt", 107, {30'b0, nxt_a}, 32'd0);
        #2;
        rst = 1'b0;
        #2;
        chk("post_rst_ye",  108, {31'b0, ye_a},  32'd0);
        chk("post_rst_nxt", 108, {30'b0, nxt_a}, 32'd1);
        @(posedge clk); #1;
        chk("post_rst_cur", 109, {30'b0, cur_a}, 32'd1);
        chk("post_rst_cnt", 109, {24'b0, cnt_a}, 32'd0);
        step(mk(0,0, 1,1,0, 0,1,0,0), 110);
        step(mk(0,0, 0,1,0, 0,2,0,0), 111);
        step(mk(0,0, 1,1,0, 0,3,0,0), 112);
        step(mk(0,0, 1,1,0, 1,1,1,0), 113);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mealy_seq_det.md
Name: mealy_seq_det

Overview:
- Parametrised Mealy serial pattern detector. It is the successor to the fixed 2-bit-state Mealy machine.
- Consumes one qualified bit per clock on xe and asserts a same-cycle Mealy match output ye when the last LEN accepted bits equal PATTERN.
- Supports overlapping and non-overlapping detection, and keeps a saturating match counter.
- Exposes the current and next state, as the previous block did, for debug and bench observation.

Parameters:
- LEN, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1011, LEN-bit target. Bit LEN-1 is the first bit received.
- OVERLAP, 1. 1 = after a match, resume from the longest proper border of PATTERN. 0 = restart from state 0.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- xe  input  1  serial data bit.
- xe_vld  input  1  qualifies xe. When low, state and counter hold and ye is 0.
- clr  input  1  synchronous clear of state and counter.
- ye  output  1  Mealy match. Combinational from cur, xe, xe_vld and rst.
- cur  output  SW  current state (matched-prefix length), SW = $clog2(LEN).
- nxt  output  SW  combinational next state.
- match_cnt  output  CNT_W  number of matches since reset/clr; saturating.
- cnt_sat  output  1  high while match_cnt is all ones.

Behaviour:
- State meaning: cur = k (0..LEN-1) means the last k accepted bits equal the first k bits of PATTERN (PATTERN[LEN-1 -: k]). cur never equals LEN.
- ye: ye = xe_vld & ~rst & (cur == LEN-1) & (xe == PATTERN[0]).
  - Zero-latency Mealy: ye is asserted in the same cycle the final bit is presented.
- nxt when xe_vld = 1 and there is no match:
  - nxt is the largest j ≤ cur+1 such that the string (first cur pattern bits followed by xe) ends with the first j pattern bits.
  - This is a KMP transition, computed at elaboration by a constant function or generate table. No runtime pattern storage.
- nxt on a match:
  - OVERLAP = 1: nxt = length of the longest proper prefix of PATTERN that is also a suffix of PATTERN.
  - OVERLAP = 0: nxt = 0.
- nxt when xe_vld = 0: nxt = cur.
- Sequential update at posedge clk:
  - cur <= clr ? 0 : nxt.
  - match_cnt: increments by 1 when ye = 1 and clr = 0. It holds at all ones, with no wrap.
  - cnt_sat = (match_cnt == all ones). Registered value compare, no extra latency.
- clr: has priority over a simultaneous match. cur and match_cnt become 0 and the match is not counted. ye still pulses combinationally in that cycle.
- rst: asynchronous.
  - Immediately forces cur = 0, match_cnt = 0 and cnt_sat = 0.
  - ye is forced to 0 while rst = 1.
  - Reset asserted mid-pattern discards the partial match; detection restarts from state 0 on the first xe_vld cycle after rst deasserts.
- Reset values: cur = 0, match_cnt = 0, cnt_sat = 0, ye = 0, nxt = 0. nxt follows cur/xe once rst is released.
- No X propagation: all case/if paths assign nxt and ye. Unused state encodings (when LEN is not a power of 2) go to state 0.
- Elaboration check: $error if LEN < 2 or LEN > 16.

Test Plan:
- Defaults (1011, OVERLAP = 1), xe_vld = 1, stream 1,0,1,1,0,1,1 -> ye high on bits 4 and 7 only. cur sequence after each edge: 1,2,3,1,2,3,1. match_cnt = 2.
- OVERLAP = 0, same stream -> ye high on bit 4 only. cur after bit 7 = 1. match_cnt = 1.
- Defaults, stream 1,0,1 then xe_vld = 0 for 3 cycles (xe toggling) then 1 -> cur holds 3 during the gap. ye is 0 during the gap and high on the final bit. match_cnt = 1.
- CNT_W = 2, OVERLAP = 1, PATTERN 4'b1111, 8 consecutive 1s -> ye high on bits 4–8 (5 matches). match_cnt = 3 after the third match and stays 3. cnt_sat rises with it.
- clr asserted in the cycle of the matching bit of 1011 -> ye pulses that cycle. Next cycle cur = 0 and match_cnt = 0.
- Stream 1,0,1 then rst pulsed asynchronously between clock edges -> cur = 0 and match_cnt = 0 without waiting for a clock edge. A following 1 does not match; a full 1,0,1,1 after release gives match_cnt = 1.
